ysyx_lsu: RTL
=============

# ysyx_lsu

Load/store unit servicing memory requests issued by the execute stage. Accepts one request at a time on the EXU-side handshake (`lsu_avalid`/`lsu_rvalid_o`/`lsu_wready_o`), runs a single AXI4-Lite-style read or write transaction on the memory bus, and returns aligned, extended load data or a store-complete pulse. It sits between `ysyx_exu` and the bus arbiter.

## Interface
- `BIT_W`, default `` `YSYX_W_WIDTH `` (32): data and address width.
- `clk` input 1: clock.
- `rst` input 1: synchronous, active-high reset.
- `lsu_avalid` input 1: EXU request valid; held high until EXU sees completion, then dropped the following cycle.
- `lsu_addr` input BIT_W: byte address (`rwaddr_o`).
- `lsu_ren`, `lsu_wen` input 1: load / store request.
- `lsu_alu_op` input 4: bits [2:0] = RV func3 (000 B, 001 H, 010 W, 100 BU, 101 HU); bit 3 ignored.
- `lsu_wdata` input BIT_W: store data, right-aligned.
- `lsu_rdata_o` output BIT_W: extended load data, valid with `lsu_rvalid_o`.
- `lsu_rvalid_o` output 1: one-cycle load-complete pulse.
- `lsu_wready_o` output 1: one-cycle store-complete pulse.
- `lsu_err_o` output 1: error flag, valid with either completion pulse.
- Bus read: `araddr_o` out BIT_W, `arvalid_o` out 1, `arready` in 1, `rdata` in BIT_W, `rresp` in 2, `rvalid` in 1, `rready_o` out 1.
- Bus write: `awaddr_o` out BIT_W, `awvalid_o` out 1, `awready` in 1, `wdata_o` out BIT_W, `wstrb_o` out BIT_W/8, `wvalid_o` out 1, `wready` in 1, `bresp` in 2, `bvalid` in 1, `bready_o` out 1.

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE: on `lsu_avalid & lsu_ren` capture addr/func3 → RADDR; on `lsu_avalid & wen & !ren` capture addr/func3/wdata → WREQ. ren&wen both set → treated as read. avalid with neither → ignored.
- RADDR: `arvalid_o`=1, `araddr_o`=captured addr; on `arready` → RDATA.
- RDATA: `rready_o`=1; on `rvalid`: shift `rdata` right by addr[1:0]*8, sign/zero-extend per func3, register into `lsu_rdata_o`, pulse `lsu_rvalid_o`, `lsu_err_o`=(rresp!=0) → DONE.
- WREQ: `awvalid_o` and `wvalid_o` asserted; each dropped independently once its ready seen; both done → WRESP. `wdata_o` = wdata << addr[1:0]*8; `wstrb_o` = {0001,0011,1111}[size] << addr[1:0].
- WRESP: `bready_o`=1; on `bvalid` pulse `lsu_wready_o`, `lsu_err_o`=(bresp!=0) → DONE.
- DONE: one cycle, `lsu_avalid` ignored (EXU still holds it this cycle) → IDLE.
- `lsu_rdata_o` holds last load value until next load completes.

## Timing
- Reset: state IDLE; all bus valids/readys, `lsu_rvalid_o`, `lsu_wready_o`, `lsu_err_o` = 0; `lsu_rdata_o` = 0.
- Load, zero-wait bus: avalid cycle 0, arvalid cycles 1, rvalid cycle 2, `lsu_rvalid_o` cycle 3, IDLE cycle 5. Earliest next acceptance cycle 5.
- Store, zero-wait: aw/w cycle 1, bvalid cycle 2, `lsu_wready_o` cycle 3.
- awready and wready in the same cycle → WRESP next cycle; in different cycles → WRESP the cycle after the later one.
- Bus valids never dropped before their ready (AXI rule). Bus inputs may stall indefinitely; no timeout.
- Reset mid-transaction: immediate return to IDLE, outstanding transaction abandoned, no completion pulse.

## Configuration
- `YSYX_LSU_MISALIGN_CHECK_EN` defined: in IDLE, H access with addr[0]!=0 or W access with addr[1:0]!=0 skips the bus, goes directly to DONE-with-pulse next cycle (`lsu_rvalid_o`/`lsu_wready_o`=1, `lsu_err_o`=1, `lsu_rdata_o` unchanged).
- Undefined: no check; address issued as-is, `wstrb_o` shifted beyond lane 3 truncated; `lsu_err_o` reflects bus response only.

## Structure
- Package `ysyx_lsu_pkg`: state enum, func3 size constants, `RESP_OKAY`=2'b00.
- Sub-module `ysyx_lsu_align`: combinational byte-lane shift, wstrb generation, load extension; FSM in `ysyx_lsu`.

## Test plan
- LW addr 0x8000_0004, bus rdata 0xDEAD_BEEF, zero wait → `lsu_rdata_o`=0xDEAD_BEEF, `lsu_rvalid_o` one cycle at cycle 3, err 0.
- LB addr 0x8000_0003, rdata 0x8012_3456 → 0xFFFF_FF80; LBU same → 0x0000_0080; LHU addr+2 → 0x0000_8012.
- SH addr 0x8000_0002, wdata 0x0000_ABCD → `wdata_o`=0xABCD_0000, `wstrb_o`=4'b1100; awready 3 cycles before wready → one `lsu_wready_o` pulse after bvalid.
- Load with rresp=2'b10 → `lsu_rvalid_o`, `lsu_err_o`=1; avalid held through DONE → no second transaction issued.
- `rst` asserted in RDATA → next cycle all outputs 0, IDLE; fresh LW completes normally.
- With macro: LW addr 0x8000_0002 → no `arvalid_o`, `lsu_rvalid_o`+`lsu_err_o` cycle 1.

Source files
------------

// File: rtl/ysyx_lsu_pkg.sv
// Shared LSU types: FSM state encoding, access-size codes, bus response code, alignment helper.
// Pure declarations; no latency or backpressure of its own.
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

package ysyx_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RADDR,
        ST_RDATA,
        ST_WREQ,
        ST_WRESP,
        ST_DONE
    } lsu_state_e;

    // Access size lives in func3[1:0]; func3[2] selects zero-extension on loads.
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic logic is_misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        if (func3[1]) begin
            return addr_lo != 2'b00;
        end
        return func3[0] & addr_lo[0];
    endfunction

endpackage

// File: rtl/ysyx_lsu_align.sv
// Byte-lane steering: store data/strobe placement and load shift + sign/zero extension.
// Latency: combinational; backpressure: none.
module ysyx_lsu_align
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = 32
) (
    input  logic [1:0]         addr_lo,
    input  logic [2:0]         func3,
    input  logic [BIT_W-1:0]   wdata,
    input  logic [BIT_W-1:0]   rdata,
    output logic [BIT_W-1:0]   wdata_sh,
    output logic [BIT_W/8-1:0] wstrb,
    output logic [BIT_W-1:0]   rdata_ext
);

    localparam int STRB_W = BIT_W / 8;

    logic [4:0]        sh_bits;
    logic [STRB_W-1:0] strb_base;
    logic [BIT_W-1:0]  rdata_sh;
    logic              sext;

    always_comb begin
        sh_bits   = {addr_lo, 3'b000};
        wdata_sh  = wdata << sh_bits;
        rdata_sh  = rdata >> sh_bits;
        sext      = ~func3[2];
        strb_base = '0;
        case (func3[1:0])
            SIZE_B:  strb_base[0]   = 1'b1;
            SIZE_H:  strb_base[1:0] = 2'b11;
            default: strb_base[3:0] = 4'b1111;
        endcase
        // Lanes pushed past the top of the bus are simply dropped.
        wstrb = strb_base << addr_lo;

        case (func3[1:0])
            SIZE_B:  rdata_ext = {{(BIT_W-8){sext & rdata_sh[7]}}, rdata_sh[7:0]};
            SIZE_H:  rdata_ext = {{(BIT_W-16){sext & rdata_sh[15]}}, rdata_sh[15:0]};
            default: rdata_ext = rdata_sh;
        endcase
    end

endmodule

// File: rtl/ysyx_lsu.sv
// Load/store unit: one EXU request -> one AXI4-Lite-style read or write; optional YSYX_LSU_MISALIGN_CHECK_EN.
// Latency: completion pulse 3 cycles after request on a zero-wait bus; bus stalls hold the FSM indefinitely.
module ysyx_lsu
    import ysyx_lsu_pkg::*;
#(
    parameter int BIT_W = `YSYX_W_WIDTH
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               lsu_avalid,
    input  logic [BIT_W-1:0]   lsu_addr,
    input  logic               lsu_ren,
    input  logic               lsu_wen,
    input  logic [3:0]         lsu_alu_op,
    input  logic [BIT_W-1:0]   lsu_wdata,
    output logic [BIT_W-1:0]   lsu_rdata_o,
    output logic               lsu_rvalid_o,
    output logic               lsu_wready_o,
    output logic               lsu_err_o,

    output logic [BIT_W-1:0]   araddr_o,
    output logic               arvalid_o,
    input  logic               arready,
    input  logic [BIT_W-1:0]   rdata,
    input  logic [1:0]         rresp,
    input  logic               rvalid,
    output logic               rready_o,

    output logic [BIT_W-1:0]   awaddr_o,
    output logic               awvalid_o,
    input  logic               awready,
    output logic [BIT_W-1:0]   wdata_o,
    output logic [BIT_W/8-1:0] wstrb_o,
    output logic               wvalid_o,
    input  logic               wready,
    input  logic [1:0]         bresp,
    input  logic               bvalid,
    output logic               bready_o
);

    lsu_state_e         state;
    lsu_state_e         state_nxt;
    logic [BIT_W-1:0]   addr_q;
    logic [BIT_W-1:0]   wdata_q;
    logic [2:0]         func3_q;
    logic               aw_done;
    logic               w_done;
    logic [BIT_W-1:0]   rdata_ext;
    logic               accept_rd;
    logic               accept_wr;
    logic               misalign;
    logic               rd_fire;
    logic               b_fire;
    logic               aw_fire;
    logic               w_fire;
    logic               op_unused;

    assign op_unused = lsu_alu_op[3];

    // A request with both enables set is serviced as a load.
    assign accept_rd = lsu_avalid & lsu_ren;
    assign accept_wr = lsu_avalid & lsu_wen & ~lsu_ren;

`ifdef YSYX_LSU_MISALIGN_CHECK_EN
    assign misalign = (accept_rd | accept_wr) & is_misaligned(lsu_alu_op[2:0], lsu_addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    ysyx_lsu_align #(
        .BIT_W (BIT_W)
    ) u_align (
        .addr_lo   (addr_q[1:0]),
        .func3     (func3_q),
        .wdata     (wdata_q),
        .rdata     (rdata),
        .wdata_sh  (wdata_o),
        .wstrb     (wstrb_o),
        .rdata_ext (rdata_ext)
    );

    assign araddr_o = addr_q;
    assign awaddr_o = addr_q;

    always_comb begin
        state_nxt = state;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        awvalid_o = 1'b0;
        wvalid_o  = 1'b0;
        bready_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (misalign) begin
                    state_nxt = ST_DONE;
                end else if (accept_rd) begin
                    state_nxt = ST_RADDR;
                end else if (accept_wr) begin
                    state_nxt = ST_WREQ;
                end
            end
            ST_RADDR: begin
                arvalid_o = 1'b1;
                if (arready) begin
                    state_nxt = ST_RDATA;
                end
            end
            // The pulse cycle is spent here with rready low, so DONE lands one cycle later.
            ST_RDATA: begin
                rready_o = ~lsu_rvalid_o;
                if (lsu_rvalid_o) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_WREQ: begin
                awvalid_o = ~aw_done;
                wvalid_o  = ~w_done;
                if ((aw_done | awready) & (w_done | wready)) begin
                    state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                bready_o = ~lsu_wready_o;
                if (lsu_wready_o) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rd_fire = rready_o & rvalid;
    assign b_fire  = bready_o & bvalid;
    assign aw_fire = awvalid_o & awready;
    assign w_fire  = wvalid_o & wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            func3_q      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            lsu_rdata_o  <= '0;
            lsu_rvalid_o <= 1'b0;
            lsu_wready_o <= 1'b0;
            lsu_err_o    <= 1'b0;
        end else begin
            state        <= state_nxt;
            lsu_rvalid_o <= rd_fire;
            lsu_wready_o <= b_fire;
            lsu_err_o    <= 1'b0;
            if (state == ST_IDLE && (accept_rd | accept_wr)) begin
                addr_q  <= lsu_addr;
                func3_q <= lsu_alu_op[2:0];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
                if (accept_wr) begin
                    wdata_q <= lsu_wdata;
                end
            end
            if (aw_fire) begin
                aw_done <= 1'b1;
            end
            if (w_fire) begin
                w_done <= 1'b1;
            end
            if (rd_fire) begin
                lsu_rdata_o <= rdata_ext;
                lsu_err_o   <= rresp != RESP_OKAY;
            end
            if (b_fire) begin
                lsu_err_o <= bresp != RESP_OKAY;
            end
`ifdef YSYX_LSU_MISALIGN_CHECK_EN
            if (state == ST_IDLE && misalign) begin
                lsu_err_o <= 1'b1;
                if (accept_rd) begin
                    lsu_rvalid_o <= 1'b1;
                end else begin
                    lsu_wready_o <= 1'b1;
                end
            end
`endif
        end
    end

endmodule
